// File: rtl/cpu_cycle_controller.sv
// cpu_cycle_controller: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the
// 16-bit CPU datapath over a shared single-port memory. Gates the opcode
// decoder's level outputs into one-cycle write/update strobes.
// Optional feature macro: CYCLE_CTRL_PERF_EN adds retired_cnt/cycle_cnt.
module cpu_cycle_controller #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [4:0] opcode,
  input  logic       dec_regwrite,
  input  logic       dec_memwrite,
  input  logic       dec_nz,
  input  logic       dec_pc_en,
  output logic       ir_load,
  output logic       mem_sel,
  output logic       mem_rd,
  output logic       mem_we,
  output logic       rf_we,
  output logic       nz_we,
  output logic       pc_we,
  output logic [2:0] state,
  output logic       busy
`ifdef CYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam int unsigned CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(MEM_LAT - 1);
  localparam logic [4:0] OP_LD = 5'b00100;
  localparam logic [4:0] OP_ST = 5'b00101;

  state_t        cur_state;
  state_t        nxt_state;
  logic [CW-1:0] lat_cnt;
  logic          lat_done;
  logic          is_ld;
  logic          is_st;

  // Memory writes are derived from the opcode, not the decoder level.
  logic unused_dec_memwrite;
  assign unused_dec_memwrite = dec_memwrite;

  assign is_ld    = (opcode == OP_LD);
  assign is_st    = (opcode == OP_ST);
  assign lat_done = (lat_cnt == LAT_LAST);
  assign state    = cur_state;
  assign busy     = (cur_state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) cur_state <= IDLE;
    else       cur_state <= nxt_state;
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    nxt_state = IDLE;
    case (cur_state)
      IDLE:    nxt_state = run ? FETCH : IDLE;
      FETCH:   nxt_state = lat_done ? DECODE : FETCH;
      DECODE:  nxt_state = EXEC;
      EXEC:    nxt_state = (is_ld || is_st) ? MEM : WB;
      MEM:     nxt_state = (is_st || lat_done) ? WB : MEM;
      WB:      nxt_state = run ? FETCH : IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  // Memory dwell counter: cleared on every state change, saturates at MEM_LAT-1
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (nxt_state != cur_state) begin
      lat_cnt <= '0;
    end else if ((cur_state == FETCH || cur_state == MEM) && !lat_done) begin
      lat_cnt <= lat_cnt + CW'(1);
    end
  end

  // Output decode from state; reset suppresses every strobe in its own cycle
  always_comb begin
    ir_load = 1'b0;
    mem_sel = 1'b0;
    mem_rd  = 1'b0;
    mem_we  = 1'b0;
    rf_we   = 1'b0;
    nz_we   = 1'b0;
    pc_we   = 1'b0;
    if (!reset) begin
      case (cur_state)
        FETCH: begin
          mem_rd  = 1'b1;
          ir_load = lat_done;
        end
        MEM: begin
          mem_sel = 1'b1;
          mem_rd  = is_ld;
          mem_we  = is_st;
        end
        WB: begin
          rf_we = is_ld ? 1'b1 : (is_st ? 1'b0 : dec_regwrite);
          nz_we = dec_nz;
          pc_we = dec_pc_en;
        end
        default: ;
      endcase
    end
  end

`ifdef CYCLE_CTRL_PERF_EN
  // Performance counters: retired instructions and busy cycles, free-wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= '0;
      cycle_cnt   <= '0;
    end else begin
      if (cur_state == WB) retired_cnt <= retired_cnt + 32'd1;
      if (busy)            cycle_cnt   <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_cycle_controller.sv
// Testbench for cpu_cycle_controller (MEM_LAT=2): directed add/ld/st/cmp
// sequence, run drop, reset during a store, then randomized instruction
// streams, all checked per cycle against a per-instruction timeline model.
module tb_cpu_cycle_controller;

  localparam int unsigned M = 2;
  localparam logic [4:0] OP_LD = 5'b00100;
  localparam logic [4:0] OP_ST = 5'b00101;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [4:0] opcode;
  logic       dec_regwrite;
  logic       dec_memwrite;
  logic       dec_nz;
  logic       dec_pc_en;
  logic       ir_load;
  logic       mem_sel;
  logic       mem_rd;
  logic       mem_we;
  logic       rf_we;
  logic       nz_we;
  logic       pc_we;
  logic [2:0] state;
  logic       busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  cpu_cycle_controller #(.MEM_LAT(M)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .dec_regwrite(dec_regwrite), .dec_memwrite(dec_memwrite),
    .dec_nz(dec_nz), .dec_pc_en(dec_pc_en),
    .ir_load(ir_load), .mem_sel(mem_sel), .mem_rd(mem_rd), .mem_we(mem_we),
    .rf_we(rf_we), .nz_we(nz_we), .pc_we(pc_we), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  // Instruction length in cycles, FETCH entry to next FETCH entry
  function automatic int unsigned ins_len(input logic [4:0] o);
    if (o == OP_LD)      return 2 * M + 3;
    else if (o == OP_ST) return M + 4;
    else                 return M + 3;
  endfunction

  // Expected {state,busy,ir_load,mem_sel,mem_rd,mem_we,rf_we,nz_we,pc_we}
  // for cycle kk of an instruction (or idle)
  function automatic logic [10:0] expect_vec(input bit idl, input int unsigned kk,
                                             input logic [4:0] o, input bit regw,
                                             input bit nz, input bit pc, input bit rst);
    logic [2:0] s;
    bit ld, stt, irl, msel, mrd, mwe, rf, nzw, pcw;
    int unsigned len;
    ld  = (o == OP_LD);
    stt = (o == OP_ST);
    len = ins_len(o);
    if (idl)               s = 3'd0;
    else if (kk < M)       s = 3'd1;
    else if (kk == M)      s = 3'd2;
    else if (kk == M + 1)  s = 3'd3;
    else if (kk == len - 1) s = 3'd5;
    else                   s = 3'd4;
    irl  = (s == 3'd1) && (kk == M - 1);
    msel = (s == 3'd4);
    mrd  = (s == 3'd1) || ((s == 3'd4) && ld);
    mwe  = (s == 3'd4) && stt;
    rf   = (s == 3'd5) && (ld || (!stt && regw));
    nzw  = (s == 3'd5) && nz;
    pcw  = (s == 3'd5) && pc;
    if (rst) begin
      irl = 0; msel = 0; mrd = 0; mwe = 0; rf = 0; nzw = 0; pcw = 0;
    end
    return {s, (s != 3'd0), irl, msel, mrd, mwe, rf, nzw, pcw};
  endfunction

  // Model of the instruction in flight
  bit          m_idle;
  int unsigned m_k;
  int unsigned m_idle_cnt;
  int unsigned m_idx;
  logic [4:0]  m_op;
  bit          m_regw, m_memw, m_nz, m_pc;

  task automatic pick_instr();
    case (m_idx)
      0: begin m_op = 5'b00001; m_regw = 1; m_memw = 0; m_nz = 0; m_pc = 1; end // add
      1: begin m_op = OP_LD;    m_regw = 0; m_memw = 0; m_nz = 0; m_pc = 1; end // ld
      2: begin m_op = OP_ST;    m_regw = 1; m_memw = 1; m_nz = 0; m_pc = 1; end // st
      3: begin m_op = 5'b01000; m_regw = 0; m_memw = 0; m_nz = 1; m_pc = 1; end // cmp
      4: begin m_op = OP_ST;    m_regw = 0; m_memw = 1; m_nz = 0; m_pc = 1; end // st, reset
      default: begin
        case ($urandom_range(0, 2))
          0:       m_op = OP_LD;
          1:       m_op = OP_ST;
          default: m_op = 5'($urandom);
        endcase
        m_regw = 1'($urandom); m_memw = 1'($urandom);
        m_nz   = 1'($urandom); m_pc   = 1'($urandom);
      end
    endcase
    m_idx++;
  endtask

  logic [10:0] got_vec;
  assign got_vec = {state, busy, ir_load, mem_sel, mem_rd, mem_we, rf_we, nz_we, pc_we};

  initial begin
    bit rst_now, run_now;
    reset = 1; run = 1; opcode = '0;
    dec_regwrite = 0; dec_memwrite = 0; dec_nz = 0; dec_pc_en = 0;
    m_idle = 1; m_k = 0; m_idle_cnt = 0; m_idx = 0;
    m_op = '0; m_regw = 0; m_memw = 0; m_nz = 0; m_pc = 0;

    repeat (3) begin
      @(posedge clk); #1;
      check_eq("reset_hold", 32'(got_vec), 32'(expect_vec(1, 0, '0, 0, 0, 0, 1)));
    end

    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      // run/reset schedule: directed instructions first, then random
      if (m_idx < 4)       run_now = 1;
      else if (m_idx == 4) run_now = m_idle ? (m_idle_cnt >= 2) : (m_k < M + 1);
      else if (m_idx == 5) run_now = 1;
      else                 run_now = ($urandom_range(0, 9) < 8);
      rst_now = (m_idx == 5 && !m_idle && m_k == M + 2) ||
                (m_idx > 5 && $urandom_range(0, 99) == 0);
      reset = rst_now; run = run_now; opcode = m_op;
      dec_regwrite = m_regw; dec_memwrite = m_memw; dec_nz = m_nz; dec_pc_en = m_pc;
      #1;
      check_eq(m_idx <= 5 ? "directed" : "random", 32'(got_vec),
               32'(expect_vec(m_idle, m_k, m_op, m_regw, m_nz, m_pc, rst_now)));
      // Advance the model by one clock edge
      if (rst_now) begin
        m_idle = 1; m_idle_cnt = 0;
      end else if (m_idle) begin
        if (run_now) begin m_idle = 0; m_k = 0; pick_instr(); end
        else m_idle_cnt++;
      end else if (m_k == ins_len(m_op) - 1) begin
        if (run_now) begin m_k = 0; pick_instr(); end
        else begin m_idle = 1; m_idle_cnt = 0; end
      end else begin
        m_k++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
